// File: rtl/fifo_unpacker.sv
// rtl/fifo_unpacker.sv - splits each upstream FIFO word into p2ratio narrower beats
// Least-significant slice first; a word reload coincides with the last beat so streaming has no bubbles.
module fifo_unpacker #(
   parameter int p1width      = 32,
   parameter int p2ratio      = 4,
   parameter int p3cntr_width = 2
) (
   input  logic                       CLK,
   input  logic                       RST_N,
   input  logic                       CLR,
   input  logic                       IN_EMPTY_N,
   input  logic [p1width-1:0]         IN_D,
   output logic                       IN_DEQ,
   output logic                       OUT_VALID,
   output logic [p1width/p2ratio-1:0] OUT_D,
   output logic                       OUT_LAST,
   input  logic                       OUT_RDY
);

   localparam int owidth = p1width / p2ratio;
   localparam logic [p3cntr_width-1:0] last_beat = p3cntr_width'(p2ratio - 1);

   if (p2ratio < 2 || (p1width % p2ratio) != 0 || (1 << p3cntr_width) < p2ratio) begin : gen_param_check
      $fatal(1, "fifo_unpacker: illegal parameters p1width=%0d p2ratio=%0d p3cntr_width=%0d",
             p1width, p2ratio, p3cntr_width);
   end

   typedef enum logic {EMPTY, SEND} state_t;

   state_t                  state_q, state_d;
   logic [p3cntr_width-1:0] beat_q, beat_d;
   logic [p1width-1:0]      hold_q;
   logic                    hold_valid;
   logic                    xfer;
   logic                    warned_q;

   assign hold_valid = (state_q == SEND);
   assign OUT_VALID  = hold_valid;
   assign OUT_LAST   = hold_valid && (beat_q == last_beat);
   assign OUT_D      = hold_q[int'(beat_q)*owidth +: owidth];
   assign xfer       = hold_valid && OUT_RDY;

   // Reset gating keeps a pop from being taken (and lost) while the block is held in reset.
   assign IN_DEQ = RST_N && IN_EMPTY_N && !CLR && (!hold_valid || (OUT_RDY && OUT_LAST));

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= EMPTY;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      if (CLR) begin
         state_d = EMPTY;
         beat_d  = '0;
      end else if (IN_DEQ) begin
         state_d = SEND;
         beat_d  = '0;
      end else if (xfer) begin
         if (OUT_LAST) begin
            state_d = EMPTY;
            beat_d  = '0;
         end else begin
            beat_d = beat_q + 1'b1;
         end
      end
   end

   // Data register has no reset; OUT_D is only meaningful while OUT_VALID is high.
   always_ff @(posedge CLK) begin
      if (IN_DEQ) begin
         hold_q <= IN_D;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         warned_q <= 1'b0;
      end else if (!warned_q && hold_valid && OUT_RDY && beat_q > last_beat) begin
         $warning("fifo_unpacker: beat counter overflow (beat=%0d)", beat_q);
         warned_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_unpacker.sv
// tb/tb_fifo_unpacker.sv - randomized and directed bench for fifo_unpacker against a queue-based model
module tb_fifo_unpacker;
   localparam int W  = 32;
   localparam int R  = 4;
   localparam int CW = 2;
   localparam int OW = W / R;

   logic          CLK = 1'b0;
   logic          RST_N, CLR, IN_EMPTY_N, IN_DEQ, OUT_VALID, OUT_LAST, OUT_RDY;
   logic [W-1:0]  IN_D;
   logic [OW-1:0] OUT_D;

   int checks   = 0;
   int failures = 0;
   int dut_deq  = 0;

   logic [W-1:0]  src_q[$];
   logic [OW-1:0] exp_q[$];

   fifo_unpacker #(.p1width(W), .p2ratio(R), .p3cntr_width(CW)) dut (
      .CLK(CLK), .RST_N(RST_N), .CLR(CLR), .IN_EMPTY_N(IN_EMPTY_N), .IN_D(IN_D),
      .IN_DEQ(IN_DEQ), .OUT_VALID(OUT_VALID), .OUT_D(OUT_D), .OUT_LAST(OUT_LAST),
      .OUT_RDY(OUT_RDY)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) if (IN_DEQ) dut_deq <= dut_deq + 1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // One clock: drive at negedge, compare against the model, then advance the model at posedge.
   task automatic step(input logic rstn, input logic clr, input logic rdy, input logic avail);
      logic         exp_deq;
      logic [W-1:0] w;
      @(negedge CLK);
      RST_N      = rstn;
      CLR        = clr;
      OUT_RDY    = rdy;
      IN_EMPTY_N = avail && (src_q.size() > 0);
      IN_D       = (src_q.size() > 0) ? src_q[0] : W'($urandom);
      #1;
      exp_deq = rstn && IN_EMPTY_N && !clr && (exp_q.size() == 0 || (rdy && exp_q.size() == 1));
      check("out_valid", OUT_VALID, exp_q.size() > 0);
      check("out_last", OUT_LAST, exp_q.size() == 1);
      if (exp_q.size() > 0) check("out_d", OUT_D, exp_q[0]);
      check("in_deq", IN_DEQ, exp_deq);
      @(posedge CLK);
      if (!rstn || clr) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
         if (exp_deq) begin
            w = src_q.pop_front();
            for (int i = 0; i < R; i++) exp_q.push_back(w[i*OW +: OW]);
         end
      end
   endtask

   initial begin
      logic [OW-1:0] beats [R];
      int            d0;
      RST_N = 1'b0; CLR = 1'b0; OUT_RDY = 1'b0; IN_EMPTY_N = 1'b0; IN_D = '0;
      beats[0] = 8'hAA; beats[1] = 8'hBB; beats[2] = 8'hCC; beats[3] = 8'hDD;

      // Reset with a word waiting: nothing may be popped.
      src_q.push_back(32'h11223344);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      check("reset_no_deq", dut_deq, 0);
      src_q.delete();

      // Single word, beats in order, one pop.
      d0 = dut_deq;
      src_q.push_back(32'hDDCCBBAA);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < R; k++) begin
         #1 check("single_beat", OUT_D, beats[k]);
         check("single_last", OUT_LAST, k == R - 1);
         step(1'b1, 1'b0, 1'b1, 1'b1);
      end
      check("single_deq_count", dut_deq - d0, 1);
      #1 check("single_idle", OUT_VALID, 0);

      // Back-to-back words: continuous valid checked by the model each cycle.
      d0 = dut_deq;
      src_q.push_back(32'h03020100); src_q.push_back(32'h13121110); src_q.push_back(32'h23222120);
      for (int k = 0; k < 3 * R + 1; k++) step(1'b1, 1'b0, 1'b1, 1'b1);
      check("b2b_deq_count", dut_deq - d0, 3);

      // Backpressure at beat 1.
      src_q.push_back(32'hDDCCBBAA);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         #1 check("bp_hold", OUT_D, 8'hBB);
         step(1'b1, 1'b0, 1'b0, 1'b1);
      end
      #1 check("bp_resume", OUT_D, 8'hBB);
      for (int k = 0; k < R; k++) step(1'b1, 1'b0, 1'b1, 1'b1);

      // Flush at beat 2, then the next word starts from its lowest slice.
      src_q.push_back(32'hDDCCBBAA); src_q.push_back(32'h44332211);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      #1 check("clr_at_beat2", OUT_D, 8'hCC);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      #1 check("clr_invalid", OUT_VALID, 0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      #1 check("clr_next_first", OUT_D, 8'h11);
      for (int k = 0; k < R; k++) step(1'b1, 1'b0, 1'b1, 1'b1);

      // Empty source.
      d0 = dut_deq;
      for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 1'($urandom), 1'b0);
      check("empty_no_deq", dut_deq - d0, 0);

      // Reset mid-word.
      src_q.push_back(32'hDDCCBBAA); src_q.push_back(32'h88776655);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      #1 check("rst_invalid", OUT_VALID, 0);
      step(1'b1, 1'b0, 1'b1, 1'b1);
      #1 check("rst_next_first", OUT_D, 8'h55);
      for (int k = 0; k < R; k++) step(1'b1, 1'b0, 1'b1, 1'b1);

      // Randomized traffic.
      for (int k = 0; k < 3000; k++) begin
         if (src_q.size() < 3) src_q.push_back(W'($urandom));
         step(($urandom_range(0, 99) != 0), ($urandom_range(0, 29) == 0),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
